// File: rtl/tt_sweep_pkg.sv
// Shared state encoding and width helpers for the truth-table sweep controller.
package tt_sweep_pkg;

    typedef enum logic [1:0] {
        IDLE,
        DRIVE,
        SAMPLE,
        DONE
    } sweep_state_t;

    function automatic int tt_width(input int nIn);
        return 1 << nIn;
    endfunction

    // One spare bit so the index can step past the last vector without wrapping.
    function automatic int idx_width(input int nIn);
        return nIn + 1;
    endfunction

    function automatic int settle_width(input int settle);
        return (settle <= 1) ? 1 : $clog2(settle);
    endfunction

endpackage

// File: rtl/tt_vec_cnt.sv
// Vector index and settle counter for the sweep; the FSM drives load/advance/tick.
module tt_vec_cnt
    import tt_sweep_pkg::*;
#(
    parameter int N_IN   = 2,
    parameter int SETTLE = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            i_load,
    input  logic            i_advance,
    input  logic            i_tick,
    output logic [N_IN-1:0] o_idx,
    output logic            o_settle_done,
    output logic            o_last
);

    localparam int IDX_W = idx_width(N_IN);
    localparam int SET_W = settle_width(SETTLE);
    localparam int TT_W  = tt_width(N_IN);

    logic [IDX_W-1:0] r_idx;
    logic [SET_W-1:0] r_settle;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_idx    <= '0;
            r_settle <= '0;
        end else if (i_load) begin
            r_idx    <= '0;
            r_settle <= '0;
        end else if (i_advance) begin
            r_idx    <= r_idx + IDX_W'(1);
            r_settle <= '0;
        end else if (i_tick) begin
            r_settle <= r_settle + SET_W'(1);
        end
    end

    assign o_idx         = r_idx[N_IN-1:0];
    assign o_settle_done = (r_settle == SET_W'(SETTLE - 1));
    assign o_last        = (r_idx == IDX_W'(TT_W - 1));

endmodule

// File: rtl/tt_sweep_ctrl.sv
// Sweeps every input vector of a combinational circuit, captures its truth table
// and flags per-output differences against a golden table.
module tt_sweep_ctrl
    import tt_sweep_pkg::*;
#(
    parameter int N_IN   = 2,
    parameter int N_OUT  = 8,
    parameter int SETTLE = 1
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          i_start,
    input  logic [N_OUT*(1<<N_IN)-1:0]    i_exp_tt,
    output logic [N_IN-1:0]               o_x_out,
    input  logic [N_OUT-1:0]              i_f_in,
    output logic                          o_busy,
    output logic                          o_res_valid,
    input  logic                          i_res_ready,
    output logic [N_OUT*(1<<N_IN)-1:0]    o_tt_out,
    output logic [N_OUT-1:0]              o_mismatch
);

    localparam int TT_W  = tt_width(N_IN);
    localparam int TBL_W = N_OUT * TT_W;

    sweep_state_t      r_state;
    logic [TBL_W-1:0]  r_exp;
    logic [TBL_W-1:0]  r_tt;
    logic [N_OUT-1:0]  r_mismatch;
    logic [N_IN-1:0]   r_x_out;
    logic              r_busy;
    logic              r_valid;

    logic [N_IN-1:0]   w_idx;
    logic              w_settle_done;
    logic              w_last;
    logic              w_load;
    logic              w_advance;
    logic              w_tick;
    logic [TBL_W-1:0]  w_tt_cap;
    logic [N_OUT-1:0]  w_mismatch;

    assign w_load    = (r_state == IDLE) && i_start;
    assign w_advance = (r_state == SAMPLE) && !w_last;
    assign w_tick    = (r_state == DRIVE) && !w_settle_done;

    tt_vec_cnt #(
        .N_IN   (N_IN),
        .SETTLE (SETTLE)
    ) u_vec_cnt (
        .clk           (clk),
        .rst_n         (rst_n),
        .i_load        (w_load),
        .i_advance     (w_advance),
        .i_tick        (w_tick),
        .o_idx         (w_idx),
        .o_settle_done (w_settle_done),
        .o_last        (w_last)
    );

    // Table as it will look after this SAMPLE, so the final compare sees the last column.
    always_comb begin
        w_tt_cap   = r_tt;
        w_mismatch = '0;
        for (int o = 0; o < N_OUT; o++) begin
            w_tt_cap[o*TT_W + int'(w_idx)] = i_f_in[o];
        end
        for (int o = 0; o < N_OUT; o++) begin
            w_mismatch[o] = (w_tt_cap[o*TT_W +: TT_W] != r_exp[o*TT_W +: TT_W]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_exp      <= '0;
            r_tt       <= '0;
            r_mismatch <= '0;
            r_x_out    <= '0;
            r_busy     <= 1'b0;
            r_valid    <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (i_start) begin
                        r_exp      <= i_exp_tt;
                        r_tt       <= '0;
                        r_mismatch <= '0;
                        r_x_out    <= '0;
                        r_busy     <= 1'b1;
                        r_state    <= DRIVE;
                    end
                end
                DRIVE: begin
                    if (w_settle_done) begin
                        r_state <= SAMPLE;
                    end
                end
                SAMPLE: begin
                    r_tt <= w_tt_cap;
                    if (w_last) begin
                        r_mismatch <= w_mismatch;
                        r_valid    <= 1'b1;
                        r_x_out    <= '0;
                        r_state    <= DONE;
                    end else begin
                        r_x_out <= w_idx + N_IN'(1);
                        r_state <= DRIVE;
                    end
                end
                DONE: begin
                    if (i_res_ready) begin
                        r_valid <= 1'b0;
                        r_busy  <= 1'b0;
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign o_x_out     = r_x_out;
    assign o_busy      = r_busy;
    assign o_res_valid = r_valid;
    assign o_tt_out    = r_tt;
    assign o_mismatch  = r_mismatch;

endmodule

// File: tb/tb_tt_sweep_ctrl.sv
// Directed bench: default 2-input instance plus a 3-input/SETTLE=3 instance.
module tb_tt_sweep_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;

    logic        start;
    logic [31:0] exp_tt;
    logic [1:0]  x_out;
    logic [7:0]  f_in;
    logic        busy;
    logic        res_valid;
    logic        res_ready;
    logic [31:0] tt_out;
    logic [7:0]  mismatch;

    logic        start2;
    logic [63:0] exp_tt2;
    logic [2:0]  x_out2;
    logic [7:0]  f_in2;
    logic        busy2;
    logic        res_valid2;
    logic        res_ready2;
    logic [63:0] tt_out2;
    logic [7:0]  mismatch2;

    int nCompared   = 0;
    int nMismatched = 0;

    localparam logic [31:0] GOLD_OK  = 32'h1060_00B2;
    localparam logic [31:0] GOLD_BAD = 32'h1070_00B2;

    always #5 clk = ~clk;

    tt_sweep_ctrl u_dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_start     (start),
        .i_exp_tt    (exp_tt),
        .o_x_out     (x_out),
        .i_f_in      (f_in),
        .o_busy      (busy),
        .o_res_valid (res_valid),
        .i_res_ready (res_ready),
        .o_tt_out    (tt_out),
        .o_mismatch  (mismatch)
    );

    tt_sweep_ctrl #(.N_IN(3), .N_OUT(8), .SETTLE(3)) u_dut3 (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_start     (start2),
        .i_exp_tt    (exp_tt2),
        .o_x_out     (x_out2),
        .i_f_in      (f_in2),
        .o_busy      (busy2),
        .o_res_valid (res_valid2),
        .i_res_ready (res_ready2),
        .o_tt_out    (tt_out2),
        .o_mismatch  (mismatch2)
    );

    // Circuits under characterisation.
    always_comb begin
        f_in     = '0;
        f_in[0]  = x_out[0] & ~x_out[1];
        f_in[1]  = ~(~x_out[0] & x_out[1]);
        f_in[5]  = x_out[0] ^ x_out[1];
        f_in[7]  = ~x_out[0] & ~x_out[1];
        f_in2    = '0;
        f_in2[0] = &x_out2;
    end

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        nCompared++;
        assert (obs === expv) else begin
            nMismatched++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [31:0] golden);
        exp_tt = golden;
        start  = 1'b1;
        tick();
        start  = 1'b0;
        exp_tt = ~golden;
    endtask

    // Start edge k, then walk edges k..k+7 and check the DONE state at k+8.
    task automatic runSweep(input logic [31:0] golden, input logic [31:0] expTt,
                            input logic [7:0] expMis, input bit pulseMid);
        applyStimulus(golden);
        for (int i = 0; i < 8; i++) begin
            checkOutput($sformatf("x_out[%0d]", i), 64'(x_out), 64'(i / 2));
            checkOutput($sformatf("busy[%0d]", i), 64'(busy), 64'd1);
            checkOutput($sformatf("res_valid[%0d]", i), 64'(res_valid), 64'd0);
            if (pulseMid && i == 4) start = 1'b1;
            if (pulseMid && i == 5) start = 1'b0;
            tick();
        end
        checkOutput("res_valid_done", 64'(res_valid), 64'd1);
        checkOutput("x_out_done", 64'(x_out), 64'd0);
        checkOutput("tt_out_done", 64'(tt_out), 64'(expTt));
        checkOutput("mismatch_done", 64'(mismatch), 64'(expMis));
        checkOutput("busy_done", 64'(busy), 64'd1);
    endtask

    initial begin
        rst_n      = 1'b0;
        start      = 1'b0;
        exp_tt     = '0;
        res_ready  = 1'b0;
        start2     = 1'b0;
        exp_tt2    = '0;
        res_ready2 = 1'b0;
        #2;
        checkOutput("rst_x_out", 64'(x_out), 64'd0);
        checkOutput("rst_busy", 64'(busy), 64'd0);
        checkOutput("rst_res_valid", 64'(res_valid), 64'd0);
        checkOutput("rst_tt_out", 64'(tt_out), 64'd0);
        checkOutput("rst_mismatch", 64'(mismatch), 64'd0);
        checkOutput("rst_tt_out2", tt_out2, 64'd0);
        tick();
        rst_n = 1'b1;
        tick();

        // Matching golden, res_ready high throughout: one-cycle res_valid pulse.
        res_ready = 1'b1;
        runSweep(GOLD_OK, GOLD_OK, 8'h00, 1'b0);
        tick();
        checkOutput("s1_valid_pulse_end", 64'(res_valid), 64'd0);
        checkOutput("s1_busy_end", 64'(busy), 64'd0);
        checkOutput("s1_tt_kept_idle", 64'(tt_out), 64'(GOLD_OK));

        // Golden with a wrong f5 column.
        runSweep(GOLD_BAD, GOLD_OK, 8'h20, 1'b0);
        tick();
        checkOutput("s2_busy_end", 64'(busy), 64'd0);
        checkOutput("s2_mismatch_kept_idle", 64'(mismatch), 64'h20);

        // Host stalls for 5 cycles after res_valid.
        res_ready = 1'b0;
        runSweep(GOLD_BAD, GOLD_OK, 8'h20, 1'b0);
        for (int i = 0; i < 5; i++) begin
            tick();
            checkOutput($sformatf("s3_valid_hold[%0d]", i), 64'(res_valid), 64'd1);
            checkOutput($sformatf("s3_busy_hold[%0d]", i), 64'(busy), 64'd1);
            checkOutput($sformatf("s3_tt_hold[%0d]", i), 64'(tt_out), 64'(GOLD_OK));
            checkOutput($sformatf("s3_mis_hold[%0d]", i), 64'(mismatch), 64'h20);
        end
        res_ready = 1'b1;
        tick();
        checkOutput("s3_valid_after_ready", 64'(res_valid), 64'd0);
        checkOutput("s3_busy_after_ready", 64'(busy), 64'd0);

        // Stray start while DRIVE of vector 2 is active.
        runSweep(GOLD_OK, GOLD_OK, 8'h00, 1'b1);
        tick();
        checkOutput("s4_busy_end", 64'(busy), 64'd0);

        // Reset while SAMPLE of vector 1 is active.
        applyStimulus(GOLD_OK);
        tick();
        tick();
        tick();
        checkOutput("s5_x_before_rst", 64'(x_out), 64'd1);
        checkOutput("s5_tt_partial", 64'(tt_out), 64'h1000_0010);
        rst_n = 1'b0;
        #1;
        checkOutput("s5_rst_busy", 64'(busy), 64'd0);
        checkOutput("s5_rst_x_out", 64'(x_out), 64'd0);
        checkOutput("s5_rst_tt_out", 64'(tt_out), 64'd0);
        checkOutput("s5_rst_res_valid", 64'(res_valid), 64'd0);
        #2;
        rst_n = 1'b1;
        tick();
        runSweep(GOLD_OK, GOLD_OK, 8'h00, 1'b0);
        tick();

        // Three-input instance, SETTLE=3: 32 cycles per sweep.
        res_ready2 = 1'b1;
        exp_tt2    = 64'h80;
        start2     = 1'b1;
        tick();
        start2  = 1'b0;
        exp_tt2 = '0;
        for (int c = 0; c < 32; c++) begin
            checkOutput($sformatf("s6_x_out[%0d]", c), 64'(x_out2), 64'(c / 4));
            checkOutput($sformatf("s6_res_valid[%0d]", c), 64'(res_valid2), 64'd0);
            tick();
        end
        checkOutput("s6_res_valid_done", 64'(res_valid2), 64'd1);
        checkOutput("s6_tt_out", tt_out2, 64'h80);
        checkOutput("s6_mismatch", 64'(mismatch2), 64'd0);
        tick();
        checkOutput("s6_busy_end", 64'(busy2), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule

// File: doc/tt_sweep_ctrl.md
# tt_sweep_ctrl

Sequencer that characterises one generated combinational circuit by driving every input vector in order and capturing each output's response into a packed truth table. It also compares the captured table against a golden table and flags per-output mismatches. It sits between a dataset-validation host and the combinational netlist under check, with the netlist's inputs and outputs wired straight to `x_out` and `f_in`.

## Interface
Parameters:
- `N_IN`, default 2, number of circuit inputs; legal range 1..8.
- `N_OUT`, default 8, number of circuit outputs.
- `SETTLE`, default 1, cycles each vector is held before it is sampled; must be at least 1.

Ports (`TT_W = 2**N_IN`):
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  begin a sweep; accepted only in IDLE.
- `exp_tt`  in  N_OUT*TT_W  golden table, captured on start acceptance.
- `x_out`  out  N_IN  input vector driven to the circuit.
- `f_in`  in  N_OUT  circuit outputs.
- `busy`  out  1  high from start acceptance until the result is consumed.
- `res_valid`  out  1  result available.
- `res_ready`  in  1  host consumes the result.
- `tt_out`  out  N_OUT*TT_W  captured table; bit `o*TT_W+v` = output o at vector v.
- `mismatch`  out  N_OUT  per-output flag: captured slice differs from the golden slice.

## Operation
- States:
  - IDLE: waits for `start`. On `start`=1, latch `exp_tt`, set the vector index to 0, clear `tt_out`, go to DRIVE.
  - DRIVE: `x_out` = vector index. Hold for SETTLE cycles, then go to SAMPLE.
  - SAMPLE: `x_out` still equals the index. Capture `f_in[o]` into `tt_out[o*TT_W+idx]` for all o. If idx = TT_W-1, go to DONE. Otherwise increment idx and go to DRIVE.
  - DONE: `res_valid`=1 and `mismatch` = per-slice `tt_out != exp_tt`. Outputs stay stable until `res_valid && res_ready`, then go to IDLE.
- Vector bit i drives `x_out[i]`. The vector index is N_IN+1 bits wide internally, so the increment never wraps during a sweep.
- `start` is ignored outside IDLE, and changes on `exp_tt` after capture have no effect.
- `x_out` returns to 0 in IDLE and DONE.
- In IDLE, `tt_out` and `mismatch` keep their last values and are only cleared by the next `start` or by reset.
- `res_ready` is ignored when `res_valid` is 0.

## Timing
- Reset value of every output: `x_out`=0, `busy`=0, `res_valid`=0, `tt_out`=0, `mismatch`=0; state is IDLE.
- Reset asserted mid-sweep forces these values immediately (asynchronously) and discards the partial sweep.
- `start` sampled at edge k: `busy`=1 and `x_out`=0 from edge k onward.
- Each vector occupies SETTLE+1 cycles.
- `res_valid` rises at edge k + TT_W*(SETTLE+1); with the defaults that is k+8.
- Consume at edge m (`res_valid`=1 and `res_ready`=1): `res_valid`=0 and `busy`=0 after edge m.
- A new `start` is accepted no earlier than edge m+1.
- `res_ready` held high through a sweep gives a single-cycle `res_valid` pulse.

## Structure
- Package `tt_sweep_pkg`:
  - state enum `sweep_state_t` {IDLE, DRIVE, SAMPLE, DONE};
  - `localparam`/function for TT_W and for the counter widths.
- Natural sub-module `tt_vec_cnt`: holds the vector index and the settle counter, with load, advance and terminal-count outputs.
- FSM, capture register and comparator stay in the top module.

## Test plan
Defaults are used unless stated. Bench circuit model: f0=x0&~x1, f5=x0^x1, f7=~x0&~x1, f1=~(~x0&x1), all other outputs 0.
1. Golden table matches the model; pulse `start`. Required: `x_out` sequence 0,0,1,1,2,2,3,3; `res_valid` at start edge+8; f0 slice=4'b0010, f1=4'b1011, f5=4'b0110, f7=4'b0001; `mismatch`=0.
2. Golden table has f5 = 4'b0111. Required: `mismatch`=8'b0010_0000; all other slices correct.
3. `res_ready` held low for 5 cycles after `res_valid`. Required: `tt_out`/`mismatch` stable, `busy`=1. When `res_ready` rises, IDLE follows on the next edge.
4. `start` pulsed during DRIVE of vector 2. Required: ignored; timing and result identical to scenario 1.
5. `rst_n` dropped while sampling vector 1. Required: immediately `busy`=0, `x_out`=0, `tt_out`=0. After release, a new `start` gives a full correct sweep.
6. N_IN=3, SETTLE=3, model f0=x0&x1&x2. Required: `res_valid` at start edge+32; f0 slice=8'h80.
